// File: rtl/maxnet_input_sequencer.sv
// Feeds four serial samples to the max-finding network, sequences init/start,
// then returns the winner index (or an all-ones abort code) over a valid/ready port.
module maxnet_input_sequencer #(
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] x4,
    output logic              init,
    output logic              start,
    input  logic              done,
    input  logic [IDX_W-1:0]  max_index,
    output logic [IDX_W-1:0]  result_index,
    output logic              result_err,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        INIT   = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        count_reg, count_next;
    logic [WD_W-1:0]   wd_reg, wd_next;
    logic [IDX_W-1:0]  res_idx_reg, res_idx_next;
    logic              res_err_reg, res_err_next;
    logic [DATA_W-1:0] word_reg [4];
    logic              in_xfer;

    // Handshake outputs decode from state only; in_ready is also masked by reset.
    assign in_ready     = (state_reg == FILL) && !rst;
    assign in_xfer      = in_valid && in_ready;
    assign init         = (state_reg == INIT);
    assign start        = (state_reg == START);
    assign result_valid = (state_reg == REPORT);
    assign busy         = (state_reg != FILL);
    assign result_index = res_idx_reg;
    assign result_err   = res_err_reg;
    assign x1           = word_reg[0];
    assign x2           = word_reg[1];
    assign x3           = word_reg[2];
    assign x4           = word_reg[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= FILL;
            count_reg   <= 2'd0;
            wd_reg      <= '0;
            res_idx_reg <= '0;
            res_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            wd_reg      <= wd_next;
            res_idx_reg <= res_idx_next;
            res_err_reg <= res_err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg[gi] <= '0;
                end else if (in_xfer && (count_reg == 2'(gi))) begin
                    word_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        wd_next      = wd_reg;
        res_idx_next = res_idx_reg;
        res_err_next = res_err_reg;
        case (state_reg)
            FILL: begin
                if (in_xfer) begin
                    count_next = count_reg + 2'd1;
                    if (count_reg == 2'd3) begin
                        count_next = 2'd0;
                        state_next = INIT;
                    end
                end
            end
            INIT: state_next = START;
            START: begin
                wd_next    = '0;
                state_next = WAIT;
            end
            WAIT: begin
                wd_next = wd_reg + WD_W'(1);
                // done takes priority over a watchdog expiry in the same cycle
                if (done) begin
                    res_idx_next = max_index;
                    res_err_next = 1'b0;
                    state_next   = REPORT;
                end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
                    res_idx_next = '1;
                    res_err_next = 1'b1;
                    state_next   = REPORT;
                end
            end
            REPORT: begin
                if (result_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end
endmodule
